snake_body_engine: RTL and testbench

- Parametrised snake-body position engine for the game datapath; generalises the fixed 5-segment tracker.
- Holds up to MAX_LEN segment coordinates on a GRID_X x GRID_Y grid and advances on an internal speed tick.
- Supports growth, reverse-turn rejection, wrap or wall mode, self-collision detection and a run/dead state machine.
- Feeds the pixel renderer (flattened coordinate buses plus valid mask) and the score/game-control logic (hit flags, length).

---
 rtl/snake_body_engine_if.sv | 43 ++++
 rtl/snake_body_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_body_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : snake_body_engine_if
// Description : Control and body-output bundle between the game controller
//               and the snake body engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface snake_body_engine_if #(
  parameter int COORD_W = 9,
  parameter int MAX_LEN = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                         start;
  logic                         restart;
  logic [1:0]                   dir;
  logic                         change_dir;
  logic                         grow;
  logic [1:0]                   interval;
  logic [MAX_LEN*COORD_W-1:0]   snake_x_flat;
  logic [MAX_LEN*COORD_W-1:0]   snake_y_flat;
  logic [MAX_LEN-1:0]           seg_valid;
  logic [LEN_W-1:0]             length;
  logic                         step;
  logic                         alive;
  logic                         self_hit;
  logic                         wall_hit;

  // Game controller side: issues commands, consumes body state
  modport master (
    output start, restart, dir, change_dir, grow, interval,
    input  snake_x_flat, snake_y_flat, seg_valid, length,
    input  step, alive, self_hit, wall_hit
  );

  // Engine side
  modport slave (
    input  start, restart, dir, change_dir, grow, interval,
    output snake_x_flat, snake_y_flat, seg_valid, length,
    output step, alive, self_hit, wall_hit
  );
endinterface
`default_nettype wire

// File: rtl/snake_body_engine.sv
`default_nettype none
// ============================================================================
// Module      : snake_body_engine
// Description : Parametrised snake body tracker: speed tick, direction
//               filtering, growth, wrap/wall edges, self-collision and a
//               IDLE/RUN/DEAD state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_body_engine #(
  parameter int COORD_W  = 9,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int GRID_X   = 320,
  parameter int GRID_Y   = 240,
  parameter int START_X  = 160,
  parameter int START_Y  = 120,
  parameter int BASE_DIV = 4,
  parameter int WRAP     = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  snake_body_engine_if.slave    bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  // Counter sized for the slowest period so a shortened period wraps naturally
  localparam int CNT_W = $clog2(BASE_DIV * 8);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam logic [1:0] DIR_PX = 2'd0;
  localparam logic [1:0] DIR_PY = 2'd1;
  localparam logic [1:0] DIR_NX = 2'd2;
  localparam logic [1:0] DIR_NY = 2'd3;

  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(GRID_X - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(GRID_Y - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_INI = LEN_W'(INIT_LEN);

  function automatic logic [COORD_W-1:0] init_x(input int idx);
    return (idx < INIT_LEN) ? COORD_W'(START_X - idx) : '0;
  endfunction

  function automatic logic [COORD_W-1:0] init_y(input int idx);
    return (idx < INIT_LEN) ? COORD_W'(START_Y) : '0;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cur_dir_q, cur_dir_d;
  logic [1:0]         pend_dir_q, pend_dir_d;
  logic               grow_pend_q, grow_pend_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic [COORD_W-1:0] seg_x_q [MAX_LEN];
  logic [COORD_W-1:0] seg_x_d [MAX_LEN];
  logic [COORD_W-1:0] seg_y_q [MAX_LEN];
  logic [COORD_W-1:0] seg_y_d [MAX_LEN];
  logic               step_q, step_d;
  logic               alive_q, alive_d;
  logic               self_hit_q, self_hit_d;
  logic               wall_hit_q, wall_hit_d;

  logic [CNT_W-1:0]   w_period_m1;
  logic               w_tick;
  logic [COORD_W-1:0] w_nx, w_ny;
  logic               w_off_grid;
  logic               w_wall;
  logic               w_grows;
  logic [LEN_W-1:0]   w_chk_len;
  logic               w_body_match;
  logic               w_self;
  logic               w_kill;

  // Speed tick: compare against the currently selected period
  always_comb begin
    w_period_m1 = CNT_W'((BASE_DIV << bus.interval) - 1);
    w_tick      = (state_q == ST_RUN) && (cnt_q == w_period_m1);
  end

  // Candidate head one cell along the pending direction, wrapped at edges
  always_comb begin
    w_nx       = seg_x_q[0];
    w_ny       = seg_y_q[0];
    w_off_grid = 1'b0;
    case (pend_dir_q)
      DIR_PX: begin
        if (seg_x_q[0] == X_MAX) begin w_nx = '0; w_off_grid = 1'b1; end
        else w_nx = seg_x_q[0] + COORD_W'(1);
      end
      DIR_PY: begin
        if (seg_y_q[0] == Y_MAX) begin w_ny = '0; w_off_grid = 1'b1; end
        else w_ny = seg_y_q[0] + COORD_W'(1);
      end
      DIR_NX: begin
        if (seg_x_q[0] == '0) begin w_nx = X_MAX; w_off_grid = 1'b1; end
        else w_nx = seg_x_q[0] - COORD_W'(1);
      end
      default: begin
        if (seg_y_q[0] == '0) begin w_ny = Y_MAX; w_off_grid = 1'b1; end
        else w_ny = seg_y_q[0] - COORD_W'(1);
      end
    endcase
    w_wall = w_off_grid && (WRAP == 0);
  end

  // Self collision: the tail cell only counts when it will not vacate
  always_comb begin
    w_grows      = grow_pend_q && (length_q < LEN_MAX);
    w_chk_len    = w_grows ? length_q : (length_q - LEN_W'(1));
    w_body_match = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < w_chk_len) && (seg_x_q[i] == w_nx) && (seg_y_q[i] == w_ny))
        w_body_match = 1'b1;
    end
    // A wall exit takes precedence; the wrapped coordinate is meaningless then
    w_self = w_body_match && !w_wall;
    w_kill = w_tick && (w_wall || w_self);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; restart overrides everything
  always_comb begin
    state_d = state_q;
    if (bus.restart) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) state_d = ST_RUN;
        ST_RUN:  if (w_kill)    state_d = ST_DEAD;
        ST_DEAD: state_d = ST_DEAD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: step pulse, alive and sticky hit flags
  always_comb begin
    step_d     = w_tick && !bus.restart;
    alive_d    = (state_d == ST_RUN);
    self_hit_d = !bus.restart && (self_hit_q || (w_tick && w_self));
    wall_hit_d = !bus.restart && (wall_hit_q || (w_tick && w_wall));
  end

  // Datapath next values: counter, direction, growth and body shift
  always_comb begin
    cnt_d       = '0;
    cur_dir_d   = cur_dir_q;
    pend_dir_d  = pend_dir_q;
    grow_pend_d = grow_pend_q;
    length_d    = length_q;
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_x_d[i] = seg_x_q[i];
      seg_y_d[i] = seg_y_q[i];
    end
    if (bus.restart) begin
      cur_dir_d   = DIR_PX;
      pend_dir_d  = DIR_PX;
      grow_pend_d = 1'b0;
      length_d    = LEN_INI;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = init_x(i);
        seg_y_d[i] = init_y(i);
      end
    end else begin
      if (state_q == ST_RUN) cnt_d = w_tick ? '0 : (cnt_q + CNT_W'(1));
      // A direct reversal would fold the head into the neck
      if (bus.change_dir && (bus.dir != (cur_dir_q ^ 2'd2))) pend_dir_d = bus.dir;
      // A grow arriving on the step cycle is kept for the following step
      grow_pend_d = (grow_pend_q && !w_tick) || bus.grow;
      if (w_tick) begin
        cur_dir_d = pend_dir_q;
        if (!w_kill) begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = w_nx;
          seg_y_d[0] = w_ny;
          if (w_grows) length_d = length_q + LEN_W'(1);
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cur_dir_q   <= DIR_PX;
      pend_dir_q  <= DIR_PX;
      grow_pend_q <= 1'b0;
      length_q    <= LEN_INI;
      step_q      <= 1'b0;
      alive_q     <= 1'b0;
      self_hit_q  <= 1'b0;
      wall_hit_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= init_y(i);
      end
    end else begin
      cnt_q       <= cnt_d;
      cur_dir_q   <= cur_dir_d;
      pend_dir_q  <= pend_dir_d;
      grow_pend_q <= grow_pend_d;
      length_q    <= length_d;
      step_q      <= step_d;
      alive_q     <= alive_d;
      self_hit_q  <= self_hit_d;
      wall_hit_q  <= wall_hit_d;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= seg_x_d[i];
        seg_y_q[i] <= seg_y_d[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
      assign bus.snake_x_flat[g*COORD_W +: COORD_W] = seg_x_q[g];
      assign bus.snake_y_flat[g*COORD_W +: COORD_W] = seg_y_q[g];
      assign bus.seg_valid[g] = (LEN_W'(g) < length_q);
    end
  endgenerate

  assign bus.length   = length_q;
  assign bus.step     = step_q;
  assign bus.alive    = alive_q;
  assign bus.self_hit = self_hit_q;
  assign bus.wall_hit = wall_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_body_engine
// Description : Self-checking bench: wrap-mode engine against a queue-based
//               body model, plus a wall-mode engine on a directed run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_body_engine;

  localparam int W  = 4;
  localparam int ML = 5;
  localparam int G  = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  snake_body_engine_if #(.COORD_W(W), .MAX_LEN(ML)) bus_w ();
  snake_body_engine_if #(.COORD_W(W), .MAX_LEN(ML)) bus_k ();

  snake_body_engine #(
    .COORD_W(W), .MAX_LEN(ML), .INIT_LEN(3), .GRID_X(G), .GRID_Y(G),
    .START_X(4), .START_Y(4), .BASE_DIV(4), .WRAP(1)
  ) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));

  snake_body_engine #(
    .COORD_W(W), .MAX_LEN(ML), .INIT_LEN(3), .GRID_X(G), .GRID_Y(G),
    .START_X(4), .START_Y(4), .BASE_DIV(4), .WRAP(0)
  ) dut_k (.clk(clk), .rst_n(rst_n), .bus(bus_k));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (wrap mode) ----------------
  int mx[$];
  int my[$];
  int mcur, mpend;
  bit mgrow, malive, mself;

  function automatic void m_init();
    mx.delete(); my.delete();
    for (int i = 0; i < 3; i++) begin mx.push_back(4 - i); my.push_back(4); end
    mcur = 0; mpend = 0; mgrow = 0; malive = 0; mself = 0;
  endfunction

  function automatic void m_dir(int d);
    if (d != (mcur ^ 2)) mpend = d;
  endfunction

  function automatic void m_step();
    int dxs[4] = '{1, 0, -1, 0};
    int dys[4] = '{0, 1, 0, -1};
    int nx, ny, n;
    bit grows, hit;
    nx = (mx[0] + dxs[mpend] + G) % G;
    ny = (my[0] + dys[mpend] + G) % G;
    grows = mgrow && (mx.size() < ML);
    mgrow = 0;
    mcur  = mpend;
    n = grows ? mx.size() : mx.size() - 1;
    hit = 0;
    for (int i = 0; i < n; i++) if (mx[i] == nx && my[i] == ny) hit = 1;
    if (hit) begin mself = 1; malive = 0; return; end
    mx.push_front(nx); my.push_front(ny);
    if (!grows) begin void'(mx.pop_back()); void'(my.pop_back()); end
  endfunction

  // Expected {x_flat, y_flat, length, seg_valid} for valid segments
  function automatic logic [47:0] exp_vec();
    logic [19:0] ex, ey;
    int          t;
    logic [2:0]  len;
    ex = '0; ey = '0;
    for (int i = 0; i < mx.size(); i++) begin
      t = mx[i]; ex[i*4 +: 4] = t[3:0];
      t = my[i]; ey[i*4 +: 4] = t[3:0];
    end
    len = 3'(mx.size());
    return {ex, ey, len, 5'((1 << mx.size()) - 1)};
  endfunction

  function automatic logic [47:0] obs_vec(input bit k);
    logic [19:0] m;
    m = '0;
    for (int i = 0; i < mx.size(); i++) m[i*4 +: 4] = 4'hF;
    if (k) return {bus_k.snake_x_flat & m, bus_k.snake_y_flat & m, bus_k.length, bus_k.seg_valid};
    return {bus_w.snake_x_flat & m, bus_w.snake_y_flat & m, bus_w.length, bus_w.seg_valid};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input bit k, input bit st, input bit rs, input bit cd, input int d, input bit gr);
    if (k) begin
      bus_k.start = st; bus_k.restart = rs; bus_k.change_dir = cd; bus_k.dir = 2'(d); bus_k.grow = gr;
    end else begin
      bus_w.start = st; bus_w.restart = rs; bus_w.change_dir = cd; bus_w.dir = 2'(d); bus_w.grow = gr;
    end
    cyc();
    bus_w.start = 0; bus_w.restart = 0; bus_w.change_dir = 0; bus_w.grow = 0;
    bus_k.start = 0; bus_k.restart = 0; bus_k.change_dir = 0; bus_k.grow = 0;
  endtask

  // Cycles until the next step pulse, -1 when it never comes
  task automatic wait_step(input bit k, output int n);
    bit s;
    n = 0;
    do begin
      cyc(); n++;
      s = k ? bus_k.step : bus_w.step;
    end while (!s && n < 200);
    if (!s) n = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int steps;
    m_init();
    total++;
    if (obs_vec(0) !== exp_vec()) begin
      bad++; $display("FAIL reset_body_w got=%h exp=%h", obs_vec(0), exp_vec());
    end
    total++;
    if (obs_vec(1) !== exp_vec()) begin
      bad++; $display("FAIL reset_body_k got=%h exp=%h", obs_vec(1), exp_vec());
    end
    total++;
    if ({bus_w.alive, bus_w.self_hit, bus_w.wall_hit, bus_w.step} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000",
                      {bus_w.alive, bus_w.self_hit, bus_w.wall_hit, bus_w.step});
    end
    steps = 0;
    for (int i = 0; i < 12; i++) begin cyc(); if (bus_w.step) steps++; end
    total++;
    if (steps !== 0 || obs_vec(0) !== exp_vec()) begin
      bad++; $display("FAIL idle_frozen steps=%0d body=%h exp_body=%h", steps, obs_vec(0), exp_vec());
    end
  endtask

  task automatic test_start_and_speed();
    int n;
    pulse(0, 1, 0, 0, 0, 0);
    malive = 1;
    wait_step(0, n);
    m_step();
    total++;
    if (n < 0 || obs_vec(0) !== exp_vec() || bus_w.alive !== 1'b1) begin
      bad++; $display("FAIL first_step n=%0d got=%h exp=%h alive=%b", n, obs_vec(0), exp_vec(), bus_w.alive);
    end
    wait_step(0, n); m_step();
    total++;
    if (n !== 4 || obs_vec(0) !== exp_vec()) begin
      bad++; $display("FAIL gap_int0 gap=%0d exp=4 body=%h exp_body=%h", n, obs_vec(0), exp_vec());
    end
    bus_w.interval = 2'd2;
    wait_step(0, n); m_step();
    total++;
    if (n !== 16 || obs_vec(0) !== exp_vec()) begin
      bad++; $display("FAIL gap_int2 gap=%0d exp=16 body=%h exp_body=%h", n, obs_vec(0), exp_vec());
    end
    bus_w.interval = 2'd0;
    wait_step(0, n); m_step();
    total++;
    if (n !== 4 || obs_vec(0) !== exp_vec()) begin
      bad++; $display("FAIL gap_back0 gap=%0d exp=4 body=%h exp_body=%h", n, obs_vec(0), exp_vec());
    end
  endtask

  task automatic test_reversal();
    int n;
    pulse(0, 0, 0, 1, 2, 0); m_dir(2);
    wait_step(0, n); m_step();
    total++;
    if (n < 0 || obs_vec(0) !== exp_vec()) begin
      bad++; $display("FAIL reverse_ignored n=%0d got=%h exp=%h", n, obs_vec(0), exp_vec());
    end
    pulse(0, 0, 0, 1, 1, 0); m_dir(1);
    wait_step(0, n); m_step();
    total++;
    if (n < 0 || obs_vec(0) !== exp_vec()) begin
      bad++; $display("FAIL turn_py n=%0d got=%h exp=%h", n, obs_vec(0), exp_vec());
    end
  endtask

  task automatic test_wrap();
    int n;
    int dirs[2] = '{0, 3};
    for (int p = 0; p < 2; p++) begin
      pulse(0, 0, 0, 1, dirs[p], 0); m_dir(dirs[p]);
      for (int s = 0; s < 9; s++) begin
        wait_step(0, n); m_step();
        total++;
        if (n < 0 || obs_vec(0) !== exp_vec() ||
            {bus_w.alive, bus_w.self_hit, bus_w.wall_hit} !== 3'b100) begin
          bad++; $display("FAIL wrap dir=%0d s=%0d got=%h exp=%h flags=%b", dirs[p], s, obs_vec(0), exp_vec(),
                          {bus_w.alive, bus_w.self_hit, bus_w.wall_hit});
        end
      end
    end
  endtask

  task automatic test_growth();
    int n;
    int exp_len[3] = '{4, 5, 5};
    for (int g = 0; g < 3; g++) begin
      pulse(0, 0, 0, 0, 0, 1); mgrow = 1;
      wait_step(0, n); m_step();
      total++;
      if (n < 0 || obs_vec(0) !== exp_vec() || int'(bus_w.length) !== exp_len[g]) begin
        bad++; $display("FAIL growth g=%0d len=%0d exp_len=%0d got=%h exp=%h", g, bus_w.length, exp_len[g],
                        obs_vec(0), exp_vec());
      end
    end
  endtask

  task automatic test_self_hit();
    int n, steps;
    int turns[3] = '{1, 2, 3};
    pulse(0, 0, 0, 1, 0, 0); m_dir(0);
    for (int s = 0; s < 5; s++) begin wait_step(0, n); m_step(); end
    for (int t = 0; t < 3; t++) begin
      pulse(0, 0, 0, 1, turns[t], 0); m_dir(turns[t]);
      wait_step(0, n); m_step();
    end
    total++;
    if (n < 0 || obs_vec(0) !== exp_vec() || mself !== 1'b1 ||
        {bus_w.alive, bus_w.self_hit, bus_w.wall_hit} !== 3'b010) begin
      bad++; $display("FAIL self_hit got=%h exp=%h flags=%b exp_flags=010", obs_vec(0), exp_vec(),
                      {bus_w.alive, bus_w.self_hit, bus_w.wall_hit});
    end
    steps = 0;
    for (int i = 0; i < 24; i++) begin cyc(); if (bus_w.step) steps++; end
    total++;
    if (steps !== 0 || obs_vec(0) !== exp_vec() || bus_w.self_hit !== 1'b1) begin
      bad++; $display("FAIL dead_frozen steps=%0d got=%h exp=%h", steps, obs_vec(0), exp_vec());
    end
    pulse(0, 0, 1, 0, 0, 0); m_init();
    total++;
    if (obs_vec(0) !== exp_vec() || {bus_w.alive, bus_w.self_hit, bus_w.wall_hit} !== 3'b000) begin
      bad++; $display("FAIL restart got=%h exp=%h flags=%b", obs_vec(0), exp_vec(),
                      {bus_w.alive, bus_w.self_hit, bus_w.wall_hit});
    end
  endtask

  task automatic test_random();
    int n, d;
    bit cd, gr;
    for (int s = 0; s < 60; s++) begin
      if (!malive) begin
        pulse(0, 0, 1, 0, 0, 0); m_init();
        pulse(0, 1, 0, 0, 0, 0); malive = 1;
      end
      bus_w.interval = 2'($urandom_range(0, 1));
      cd = 1'($urandom_range(0, 1));
      gr = ($urandom_range(0, 3) == 0);
      d  = $urandom_range(0, 3);
      pulse(0, 0, 0, cd, d, gr);
      if (cd) m_dir(d);
      if (gr) mgrow = 1;
      wait_step(0, n); m_step();
      total++;
      if (n !== (4 << bus_w.interval) - 1 || obs_vec(0) !== exp_vec() ||
          {bus_w.alive, bus_w.self_hit, bus_w.wall_hit} !== {malive, mself, 1'b0}) begin
        bad++; $display("FAIL random s=%0d gap=%0d got=%h exp=%h flags=%b exp_flags=%b%b0", s, n,
                        obs_vec(0), exp_vec(), {bus_w.alive, bus_w.self_hit, bus_w.wall_hit}, malive, mself);
      end
    end
    bus_w.interval = 2'd0;
  endtask

  task automatic test_wall();
    int n;
    pulse(1, 1, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      wait_step(1, n);
      total++;
      if (n < 0 || int'(bus_k.snake_x_flat[3:0]) !== 5 + s || bus_k.snake_y_flat[3:0] !== 4'd4 ||
          bus_k.alive !== 1'b1) begin
        bad++; $display("FAIL wall_walk s=%0d head=(%0d,%0d) exp=(%0d,4) alive=%b", s,
                        bus_k.snake_x_flat[3:0], bus_k.snake_y_flat[3:0], 5 + s, bus_k.alive);
      end
    end
    wait_step(1, n);
    total++;
    if (n !== 4 || bus_k.snake_x_flat[3:0] !== 4'd7 || bus_k.snake_y_flat[3:0] !== 4'd4 ||
        bus_k.length !== 3'd3 || {bus_k.alive, bus_k.self_hit, bus_k.wall_hit} !== 3'b001) begin
      bad++; $display("FAIL wall_hit gap=%0d head=(%0d,%0d) exp=(7,4) len=%0d flags=%b exp_flags=001", n,
                      bus_k.snake_x_flat[3:0], bus_k.snake_y_flat[3:0], bus_k.length,
                      {bus_k.alive, bus_k.self_hit, bus_k.wall_hit});
    end
  endtask

  task automatic test_async_reset();
    int n;
    pulse(0, 0, 1, 0, 0, 0); m_init();
    pulse(0, 1, 0, 0, 0, 0);
    wait_step(0, n);
    total++;
    if (n < 0 || bus_w.snake_x_flat[3:0] !== 4'd5) begin
      bad++; $display("FAIL pre_reset_step n=%0d head_x=%0d exp=5", n, bus_w.snake_x_flat[3:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs_vec(0) !== exp_vec() || bus_w.alive !== 1'b0 || bus_k.wall_hit !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%h exp=%h alive=%b wall_k=%b", obs_vec(0), exp_vec(),
                      bus_w.alive, bus_k.wall_hit);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus_w.start = 0; bus_w.restart = 0; bus_w.dir = 0; bus_w.change_dir = 0; bus_w.grow = 0; bus_w.interval = 0;
    bus_k.start = 0; bus_k.restart = 0; bus_k.dir = 0; bus_k.change_dir = 0; bus_k.grow = 0; bus_k.interval = 0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    test_reset();
    test_start_and_speed();
    test_reversal();
    test_wrap();
    test_growth();
    test_self_hit();
    test_random();
    test_wall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
